// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential BCD-to-binary converter (reverse double-dabble).
//
// Takes NDIG packed BCD digits (ONES in the least significant nibble) and
// returns the value as a BW-bit binary number, modulo 2^BW. The conversion
// uses one shift-right-and-correct step per clock and a start/busy/done
// handshake. The latency from the start edge to done is BW+1 clocks.
//
// Optional feature, selected by the macro BCD_DIGIT_CHECK_EN:
//   When the macro is defined, any input nibble above 9 at the start edge sets
//   a latched illegal flag. The conversion still takes the full latency. At
//   FINISH the flag drives err, and bin_out and ovf are forced to zero.
//   When the macro is not defined, err is tied low and illegal nibbles are
//   converted raw. That result is deterministic but has no meaning.
module bcd_to_binary_seq #(
    parameter int NDIG = 3,
    parameter int BW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [BW-1:0]     bin_out,
    output logic              ovf,
    output logic              err
);

    localparam int DW = 4 * NDIG;        // width of the BCD field
    localparam int WW = DW + BW;         // width of the work register
    localparam int CW = $clog2(BW + 1);  // width of the iteration counter
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // The upper DW bits hold the BCD field and the lower BW bits hold the binary field.
    logic [WW-1:0] w_reg;
    logic [WW-1:0] w_shift;
    logic [WW-1:0] w_step;
    logic [CW-1:0] cnt_reg;
    logic          last_shift;
    logic          start_accept;

    assign start_accept = (state_reg == IDLE) && start;
    assign last_shift   = (cnt_reg == LAST);

    // ------------------------------------------------------------------
    // One reverse double-dabble step. Shift the whole register right by
    // one bit. Then fix up each BCD nibble on its own: a nibble of 8 or
    // more after the shift had a bit move in from the digit above. That
    // bit is worth 5 in this digit, but the plain shift made it worth 8,
    // so subtract 3.
    // ------------------------------------------------------------------
    assign w_shift = {1'b0, w_reg[WW-1:1]};
    assign w_step[BW-1:0] = w_shift[BW-1:0];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib_fix
            logic [3:0] nib;
            assign nib = w_shift[BW+4*gi +: 4];
            assign w_step[BW+4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
        end
    endgenerate

`ifdef BCD_DIGIT_CHECK_EN
    // Check every input digit for a value above 9 (digits A..F).
    logic [NDIG-1:0] nib_illegal;
    logic            flag_reg;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib_chk
            assign nib_illegal[gi] = (bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Latch the illegal-digit flag at each accepted start; it is held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_reg <= 1'b0;
        end else if (start_accept) begin
            flag_reg <= |nib_illegal;
        end
    end

    // err is loaded at FINISH, so it always goes with bin_out and ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state_reg == FINISH) begin
            err <= flag_reg;
        end
    end
`else
    assign err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: one IDLE cycle, BW SHIFT cycles, then one FINISH cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: busy covers every cycle outside IDLE.
    always_comb begin
        busy = 1'b0;
        if (state_reg != IDLE) begin
            busy = 1'b1;
        end
    end

    // Work register and iteration counter. The input is captured only at an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_reg   <= {bcd_in, {BW{1'b0}}};
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    w_reg   <= w_step;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers and the done pulse. They change only at FINISH, so they
    // stay stable for the whole of the next conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_reg == FINISH) begin
                done <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                if (flag_reg) begin
                    bin_out <= '0;
                    ovf     <= 1'b0;
                end else begin
                    bin_out <= w_reg[BW-1:0];
                    ovf     <= |w_reg[WW-1:BW];
                end
`else
                bin_out <= w_reg[BW-1:0];
                // Any residue left in the BCD field after BW shifts means the value was 2^BW or more.
                ovf     <= |w_reg[WW-1:BW];
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed testbench for bcd_to_binary_seq (NDIG=3, BW=8).
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  bin_out;
    logic        ovf;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_to_binary_seq #(.NDIG(3), .BW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Stimulus only: pulse start with value v. Then wait (bounded) for done.
    // cyc = negedges after the start edge; bcnt = busy samples before done.
    task automatic do_conv(input logic [11:0] v, output int cyc, output int bcnt);
        start  = 1'b1;
        bcd_in = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        bcnt  = 0;
        while (done !== 1'b1 && cyc < 30) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (bin_out !== 8'h00) begin errors++; $display("FAIL reset_bin got %h want 00", bin_out); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: busy=%b done=%b bin=%h", busy, done, bin_out);
    endtask

    task automatic test_zero();
        int cyc, bcnt;
        do_conv(12'h000, cyc, bcnt);
        checks++; if (cyc !== 9)         begin errors++; $display("FAIL zero_latency got %0d want 9", cyc); end
        checks++; if (bin_out !== 8'h00) begin errors++; $display("FAIL zero_bin got %h want 00", bin_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL zero_ovf got %b want 0", ovf); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL zero_err got %b want 0", err); end
        $display("conv 000 -> bin=%h ovf=%b lat=%0d", bin_out, ovf, cyc);
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        do_conv(12'h123, cyc, bcnt);
        checks++; if (cyc !== 9)         begin errors++; $display("FAIL basic_latency got %0d want 9", cyc); end
        checks++; if (bcnt !== 9)        begin errors++; $display("FAIL basic_busy_cycles got %0d want 9", bcnt); end
        checks++; if (bin_out !== 8'h7B) begin errors++; $display("FAIL basic_bin got %h want 7b", bin_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
        $display("conv 123 -> bin=%h ovf=%b lat=%0d busy=%0d", bin_out, ovf, cyc, bcnt);
        @(negedge clk);
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++; if (bin_out !== 8'h7B) begin errors++; $display("FAIL basic_hold got %h want 7b", bin_out); end
    endtask

    task automatic test_boundaries();
        logic [11:0] vin [3] = '{12'h255, 12'h256, 12'h999};
        logic [7:0]  vexp[3] = '{8'hFF, 8'h00, 8'hE7};
        logic        oexp[3] = '{1'b0, 1'b1, 1'b1};
        int cyc, bcnt;
        for (int i = 0; i < 3; i++) begin
            do_conv(vin[i], cyc, bcnt);
            checks++; if (cyc !== 9)          begin errors++; $display("FAIL bound_latency in=%h got %0d want 9", vin[i], cyc); end
            checks++; if (bin_out !== vexp[i]) begin errors++; $display("FAIL bound_bin in=%h got %h want %h", vin[i], bin_out, vexp[i]); end
            checks++; if (ovf !== oexp[i])     begin errors++; $display("FAIL bound_ovf in=%h got %b want %b", vin[i], ovf, oexp[i]); end
            $display("conv %h -> bin=%h ovf=%b", vin[i], bin_out, ovf);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, seen, ndone;
        start  = 1'b1;
        bcd_in = 12'h042;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        seen  = -1;
        ndone = 0;
        while (cyc < 25) begin
            if (cyc == 3) begin
                start  = 1'b1;
                bcd_in = 12'h900;
            end else begin
                start = 1'b0;
                if (cyc == 5) bcd_in = 12'h555;
            end
            if (cyc == 6) begin
                checks++; if (bin_out !== 8'hE7) begin errors++; $display("FAIL ignore_hold_prev got %h want e7", bin_out); end
            end
            if (done === 1'b1) begin
                if (seen < 0) seen = cyc;
                ndone++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (seen !== 9)        begin errors++; $display("FAIL ignore_latency got %0d want 9", seen); end
        checks++; if (ndone !== 1)       begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (bin_out !== 8'h2A) begin errors++; $display("FAIL ignore_bin got %h want 2a", bin_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL ignore_ovf got %b want 0", ovf); end
        $display("conv 042 (with start while busy) -> bin=%h dones=%0d", bin_out, ndone);
    endtask

    task automatic test_reset_abort();
        int cyc, bcnt, ndone;
        start  = 1'b1;
        bcd_in = 12'h077;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (bin_out !== 8'h00) begin errors++; $display("FAIL abort_bin got %h want 00", bin_out); end
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0)       begin errors++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        do_conv(12'h077, cyc, bcnt);
        checks++; if (cyc !== 9)         begin errors++; $display("FAIL abort_rerun_latency got %0d want 9", cyc); end
        checks++; if (bin_out !== 8'h4D) begin errors++; $display("FAIL abort_rerun_bin got %h want 4d", bin_out); end
        $display("abort then conv 077 -> bin=%h", bin_out);
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2;
        logic [7:0] v1, v2;
        start  = 1'b1;
        bcd_in = 12'h100;
        @(posedge clk);
        @(negedge clk);
        bcd_in = 12'h200;
        cyc = 0;
        d1  = -1;
        d2  = -1;
        v1  = 8'h00;
        v2  = 8'h00;
        while (cyc < 22) begin
            if (done === 1'b1) begin
                if (d1 < 0) begin d1 = cyc; v1 = bin_out; end
                else if (d2 < 0) begin d2 = cyc; v2 = bin_out; end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++; if (d1 !== 9)     begin errors++; $display("FAIL b2b_first_done got %0d want 9", d1); end
        checks++; if (v1 !== 8'h64) begin errors++; $display("FAIL b2b_first_bin got %h want 64", v1); end
        checks++; if (d2 !== 19)    begin errors++; $display("FAIL b2b_second_done got %0d want 19", d2); end
        checks++; if (v2 !== 8'hC8) begin errors++; $display("FAIL b2b_second_bin got %h want c8", v2); end
        $display("back-to-back: done@%0d bin=%h, done@%0d bin=%h", d1, v1, d2, v2);
        // Let the third conversion, started while start was still high, run to completion.
        repeat (15) @(negedge clk);
    endtask

    task automatic test_digit_check();
        int cyc, bcnt;
        do_conv(12'h1A5, cyc, bcnt);
        checks++; if (cyc !== 9)         begin errors++; $display("FAIL digit_latency got %0d want 9", cyc); end
`ifdef BCD_DIGIT_CHECK_EN
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL digit_err got %b want 1", err); end
        checks++; if (bin_out !== 8'h00) begin errors++; $display("FAIL digit_bin got %h want 00", bin_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL digit_ovf got %b want 0", ovf); end
`else
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL digit_err_off got %b want 0", err); end
`endif
        $display("conv 1A5 -> bin=%h ovf=%b err=%b", bin_out, ovf, err);
        do_conv(12'h105, cyc, bcnt);
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL digit_clear_err got %b want 0", err); end
        checks++; if (bin_out !== 8'h69) begin errors++; $display("FAIL digit_clear_bin got %h want 69", bin_out); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL digit_clear_ovf got %b want 0", ovf); end
        $display("conv 105 -> bin=%h ovf=%b err=%b", bin_out, ovf, err);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero();
        test_basic();
        test_boundaries();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_digit_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
